// File: rtl/dff_pipe_if.sv
// Valid/ready bundle for the dff_pipe register pipeline: upstream push side
// and downstream pop side. The environment is the master, the pipe is the slave.
interface dff_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH register pipeline with valid/ready flow control, bubble
// collapsing, synchronous flush and a registered occupancy count.
module dff_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    dff_pipe_if.slave        bus,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_d;
    logic [CNT_W-1:0]            count_q;
    logic [CNT_W-1:0]            count_d;
    logic                        in_ready_w;
    logic                        in_xfer;
    logic                        out_xfer;

    // A stage advances when it is valid and the stage ahead is empty or itself
    // advancing; this backwards chain is what lets bubbles collapse.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = v_q[DEPTH-1] & bus.out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
    end

    always_comb begin
        in_ready_w = ~flush & (~v_q[0] | adv[0]);
        in_xfer    = bus.in_valid & in_ready_w;
        out_xfer   = adv[DEPTH-1];

        load    = '0;
        load[0] = in_xfer;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = ~flush & v_q[k-1] & (~v_q[k] | adv[k]);
        end

        v_d = v_q;
        d_d = d_q;
        d_d[0] = load[0] ? bus.in_data : d_q[0];
        for (int k = 1; k < DEPTH; k++) begin
            d_d[k] = load[k] ? d_q[k-1] : d_q[k];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (flush) begin
                v_d[k] = 1'b0;
            end else if (load[k]) begin
                v_d[k] = 1'b1;
            end else if (adv[k]) begin
                v_d[k] = 1'b0;
            end
        end

        // Flush drops every word even if the head leaves this same cycle.
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            d_q     <= {DEPTH{RST_VAL}};
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_data  = d_q[DEPTH-1];
    assign count         = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a DEPTH=4/WIDTH=8 instance and a
// DEPTH=1/WIDTH=32 instance, exercised one after the other.
module tb_dff_pipe;

    typedef struct {
        logic        iv;
        logic [31:0] data;
        logic        ordy;
        logic        fl;
        logic        ir;
        logic        ov;
        logic [31:0] od;
        int          cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fl4 = 1'b0;
    logic       fl1 = 1'b0;
    logic [2:0] cnt4;
    logic [0:0] cnt1;
    int         checks = 0;
    int         errors = 0;

    vec_t tab4[16];
    vec_t tab1[8];

    dff_pipe_if #(.WIDTH(8))  bus4 ();
    dff_pipe_if #(.WIDTH(32)) bus1 ();

    dff_pipe #(.WIDTH(8), .DEPTH(4)) u4 (
        .clk   (clk),
        .rst   (rst),
        .flush (fl4),
        .bus   (bus4.slave),
        .count (cnt4)
    );

    dff_pipe #(.WIDTH(32), .DEPTH(1)) u1 (
        .clk   (clk),
        .rst   (rst),
        .flush (fl1),
        .bus   (bus1.slave),
        .count (cnt1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input logic [31:0] data, input logic ordy,
                                input logic fl, input logic ir, input logic ov,
                                input logic [31:0] od, input int cnt);
        vec_t r;
        r.iv = iv; r.data = data; r.ordy = ordy; r.fl = fl;
        r.ir = ir; r.ov = ov; r.od = od; r.cnt = cnt;
        return r;
    endfunction

    function automatic logic [31:0] get_ov(input int sel);
        return (sel == 4) ? 32'(bus4.out_valid) : 32'(bus1.out_valid);
    endfunction

    function automatic logic [31:0] get_ir(input int sel);
        return (sel == 4) ? 32'(bus4.in_ready) : 32'(bus1.in_ready);
    endfunction

    function automatic logic [31:0] get_od(input int sel);
        return (sel == 4) ? 32'(bus4.out_data) : bus1.out_data;
    endfunction

    function automatic logic [31:0] get_cnt(input int sel);
        return (sel == 4) ? 32'(cnt4) : 32'(cnt1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic iv, input logic [31:0] data,
                                 input logic ordy, input logic fl);
        if (sel == 4) begin
            bus4.in_valid  = iv;
            bus4.in_data   = data[7:0];
            bus4.out_ready = ordy;
            fl4            = fl;
        end else begin
            bus1.in_valid  = iv;
            bus1.in_data   = data;
            bus1.out_ready = ordy;
            fl1            = fl;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input int sel, input string tag, input logic ir, input logic ov,
                              input logic [31:0] od, input int cnt);
        checkOutput({tag, " in_ready"}, get_ir(sel), 32'(ir));
        checkOutput({tag, " out_valid"}, get_ov(sel), 32'(ov));
        if (ov) checkOutput({tag, " out_data"}, get_od(sel), od);
        checkOutput({tag, " count"}, get_cnt(sel), 32'(cnt));
    endtask

    // Reset held with a word offered, then the word walks through to the output.
    task automatic resetScenario(input int sel, input int depth, input logic [31:0] pat);
        rst = 1'b1;
        applyStimulus(sel, 1'b1, pat, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput($sformatf("rst%0d out_valid", sel), get_ov(sel), 32'd0);
        checkOutput($sformatf("rst%0d count", sel), get_cnt(sel), 32'd0);
        checkOutput($sformatf("rst%0d out_data", sel), get_od(sel), 32'd0);
        rst = 1'b0;
        tick();
        applyStimulus(sel, 1'b0, 32'd0, 1'b1, 1'b0);
        for (int k = 1; k <= depth; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst%0d lat%0d out_valid", sel, k), get_ov(sel), 32'(k == depth));
            checkOutput($sformatf("rst%0d lat%0d count", sel, k), get_cnt(sel), 32'd1);
            if (k == depth) checkOutput($sformatf("rst%0d out_data", sel), get_od(sel), pat);
            tick();
        end
        @(negedge clk);
        checkOutput($sformatf("rst%0d drained out_valid", sel), get_ov(sel), 32'd0);
        checkOutput($sformatf("rst%0d drained count", sel), get_cnt(sel), 32'd0);
        tick();
    endtask

    task automatic streamScenario(input int sel, input int depth, input logic [31:0] base);
        int acc;
        int emitted;
        logic exp_ov;
        for (int c = 0; c <= 16 + depth; c++) begin
            applyStimulus(sel, c < 16, base + 32'(c), 1'b1, 1'b0);
            @(negedge clk);
            acc     = (c < 16) ? c : 16;
            emitted = (c - depth < 0) ? 0 : ((c - depth > 16) ? 16 : c - depth);
            exp_ov  = (c >= depth) && (c < 16 + depth);
            checkState(sel, $sformatf("stream%0d c%0d", sel, c), 1'b1, exp_ov,
                       base + 32'(c - depth), acc - emitted);
            tick();
        end
    endtask

    task automatic asyncResetScenario(input int sel, input int depth, input logic [31:0] base);
        for (int t = 0; t < depth + 2; t++) begin
            applyStimulus(sel, 1'b1, base + 32'(t), 1'b1, 1'b0);
            tick();
        end
        checkOutput($sformatf("arst%0d pre out_valid", sel), get_ov(sel), 32'd1);
        checkOutput($sformatf("arst%0d pre out_data", sel), get_od(sel), base + 32'd2);
        checkOutput($sformatf("arst%0d pre count", sel), get_cnt(sel), 32'(depth));
        applyStimulus(sel, 1'b0, 32'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput($sformatf("arst%0d async out_valid", sel), get_ov(sel), 32'd0);
        checkOutput($sformatf("arst%0d async count", sel), get_cnt(sel), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < depth + 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("arst%0d idle%0d out_valid", sel, i), get_ov(sel), 32'd0);
            tick();
        end
        resetScenario(sel, depth, base ^ 32'h5A);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Stall/collapse, full with simultaneous in/out, then flush with 7E offered.
        tab4[0]  = mk(1, 32'h11, 0, 0, 1, 0, 32'h00, 0);
        tab4[1]  = mk(1, 32'h22, 0, 0, 1, 0, 32'h00, 1);
        tab4[2]  = mk(0, 32'h00, 0, 0, 1, 0, 32'h00, 2);
        tab4[3]  = mk(0, 32'h00, 0, 0, 1, 0, 32'h00, 2);
        tab4[4]  = mk(0, 32'h00, 0, 0, 1, 1, 32'h11, 2);
        tab4[5]  = mk(1, 32'h33, 0, 0, 1, 1, 32'h11, 2);
        tab4[6]  = mk(1, 32'h44, 0, 0, 1, 1, 32'h11, 3);
        tab4[7]  = mk(1, 32'h55, 0, 0, 0, 1, 32'h11, 4);
        tab4[8]  = mk(1, 32'h55, 1, 0, 1, 1, 32'h11, 4);
        tab4[9]  = mk(1, 32'h66, 1, 0, 1, 1, 32'h22, 4);
        tab4[10] = mk(0, 32'h00, 1, 0, 1, 1, 32'h33, 4);
        tab4[11] = mk(1, 32'h7E, 0, 1, 0, 1, 32'h44, 3);
        tab4[12] = mk(0, 32'h00, 1, 0, 1, 0, 32'h00, 0);
        tab4[13] = mk(0, 32'h00, 1, 0, 1, 0, 32'h00, 0);
        tab4[14] = mk(0, 32'h00, 1, 0, 1, 0, 32'h00, 0);
        tab4[15] = mk(0, 32'h00, 1, 0, 1, 0, 32'h00, 0);

        tab1[0] = mk(1, 32'hA1A1_0001, 0, 0, 1, 0, 32'h0, 0);
        tab1[1] = mk(1, 32'hB2B2_0002, 0, 0, 0, 1, 32'hA1A1_0001, 1);
        tab1[2] = mk(1, 32'hB2B2_0002, 0, 0, 0, 1, 32'hA1A1_0001, 1);
        tab1[3] = mk(1, 32'hB2B2_0002, 1, 0, 1, 1, 32'hA1A1_0001, 1);
        tab1[4] = mk(1, 32'hC3C3_0003, 1, 0, 1, 1, 32'hB2B2_0002, 1);
        tab1[5] = mk(1, 32'h7E7E_007E, 0, 1, 0, 1, 32'hC3C3_0003, 1);
        tab1[6] = mk(0, 32'h0, 1, 0, 1, 0, 32'h0, 0);
        tab1[7] = mk(0, 32'h0, 1, 0, 1, 0, 32'h0, 0);

        applyStimulus(4, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 1'b0);

        resetScenario(4, 4, 32'hA5);
        streamScenario(4, 4, 32'h00);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4, tab4[i].iv, tab4[i].data, tab4[i].ordy, tab4[i].fl);
            @(negedge clk);
            checkState(4, $sformatf("tab4 row%0d", i), tab4[i].ir, tab4[i].ov, tab4[i].od, tab4[i].cnt);
            tick();
        end
        asyncResetScenario(4, 4, 32'h90);
        applyStimulus(4, 1'b0, 32'd0, 1'b0, 1'b0);

        resetScenario(1, 1, 32'hA5A5_A5A5);
        streamScenario(1, 1, 32'hC0DE_0000);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, tab1[i].iv, tab1[i].data, tab1[i].ordy, tab1[i].fl);
            @(negedge clk);
            checkState(1, $sformatf("tab1 row%0d", i), tab1[i].ir, tab1[i].ov, tab1[i].od, tab1[i].cnt);
            tick();
        end
        asyncResetScenario(1, 1, 32'h1234_5600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
